// File: rtl/apb4_mem_slave.sv
// APB4 word-addressed memory slave with PREADY wait states, registered reads and PSLVERR.
// Optional PPROT region protection is compiled in when APB4_MEM_SLAVE_PROT_EN is defined.
module apb4_mem_slave #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int RD_WAIT   = 1,
    parameter int WR_WAIT   = 0,
    parameter int PROT_BASE = DEPTH / 2
) (
    input  logic              PCLK_i,
    input  logic              PRESET_i,
    input  logic              PSEL_i,
    input  logic              PENABLE_i,
    input  logic              PWRITE_i,
    input  logic [ADDR_W-1:0] PADDR_i,
    input  logic [DATA_W-1:0] PWDATA_i,
    input  logic [DATA_W/8-1:0] PSTRB_i,
    input  logic [2:0]        PPROT_i,
    output logic [DATA_W-1:0] PRDATA_o,
    output logic              PREADY_o,
    output logic              PSLVERR_o
);

    localparam int NB = DATA_W / 8;
    localparam int BO = $clog2(NB);
    localparam int IW = ADDR_W - BO;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW:0] DEPTH_L = (IW + 1)'(DEPTH);
    localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
    localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

    // DONE is folded into IDLE: a setup phase seen in IDLE covers back-to-back transfers.
    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic [3:0]        cnt_next;
    logic              write_q;
    logic [MW-1:0]     idx_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [IW-1:0]     idx;
    logic              setup;
    logic              complete;
    logic              prot_err;
    logic              err_in;

    assign idx      = PADDR_i[ADDR_W-1:BO];
    assign setup    = PSEL_i & ~PENABLE_i;
    assign complete = (state == ACCESS) & PSEL_i & PENABLE_i & (cnt == 4'd0);

`ifdef APB4_MEM_SLAVE_PROT_EN
    localparam logic [IW:0] PROT_L = (IW + 1)'(PROT_BASE);
    // Upper region needs privileged (PPROT[0]) and secure (PPROT[1] low) access.
    assign prot_err = ({1'b0, idx} >= PROT_L) & ~(PPROT_i[0] & ~PPROT_i[1]);
`else
    localparam int unused_prot_base = PROT_BASE;
    logic unused_prot;
    assign unused_prot = ^PPROT_i;
    assign prot_err    = 1'b0;
`endif

    assign err_in = (PADDR_i[BO-1:0] != '0) | ({1'b0, idx} >= DEPTH_L) | prot_err;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (setup) begin
            state_next = ACCESS;
            cnt_next   = PWRITE_i ? WR_CNT : RD_CNT;
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                ACCESS: begin
                    if (!PSEL_i) begin
                        state_next = IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt_next = cnt - 4'd1;
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK_i or posedge PRESET_i) begin
        if (PRESET_i) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            write_q <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (setup) begin
                write_q <= PWRITE_i;
                idx_q   <= idx[MW-1:0];
                err_q   <= err_in;
                rdata_q <= err_in ? '0 : mem[idx[MW-1:0]];
            end
        end
    end

    // Memory is intentionally not reset so it maps onto block RAM.
    always_ff @(posedge PCLK_i) begin
        if (complete & write_q & ~err_q) begin
            for (int b = 0; b < NB; b++) begin
                if (PSTRB_i[b]) begin
                    mem[idx_q][b*8 +: 8] <= PWDATA_i[b*8 +: 8];
                end
            end
        end
    end

    assign PREADY_o  = complete;
    assign PSLVERR_o = complete & err_q;
    assign PRDATA_o  = (complete & ~write_q & ~err_q) ? rdata_q : '0;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Self-checking bench for apb4_mem_slave: directed and random APB transfers against a word-array model.
// Expectations follow APB4_MEM_SLAVE_PROT_EN when it is defined for the build.
module tb_apb4_mem_slave;

    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int RDW   = 3;
    localparam int WRW   = 2;
    localparam int PB    = 512;
`ifdef APB4_MEM_SLAVE_PROT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          preset;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem   [DEPTH];
    bit          model_valid [DEPTH];

    apb4_mem_slave #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH),
        .RD_WAIT(RDW), .WR_WAIT(WRW), .PROT_BASE(PB)
    ) dut (
        .PCLK_i(clk), .PRESET_i(preset), .PSEL_i(psel), .PENABLE_i(penable),
        .PWRITE_i(pwrite), .PADDR_i(paddr), .PWDATA_i(pwdata), .PSTRB_i(pstrb),
        .PPROT_i(pprot), .PRDATA_o(prdata), .PREADY_o(pready), .PSLVERR_o(pslverr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no end, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit modelErr(input int unsigned a, input logic [2:0] prot);
        bit e;
        e = ((a % 4) != 0) || ((a / 4) >= DEPTH);
        if (PROT_ON && ((a / 4) >= PB) && !(prot[0] && !prot[1])) e = 1'b1;
        return e;
    endfunction

    task automatic idleCycle();
        @(negedge clk);
        psel = 1'b0;
        penable = 1'b0;
        #1;
        checkOutput("idle_pready", 32'(pready), 32'd0);
        checkOutput("idle_prdata", prdata, 32'd0);
        checkOutput("idle_pslverr", 32'(pslverr), 32'd0);
    endtask

    task automatic driveSetup(input bit wr, input int unsigned addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [2:0] prot);
        @(negedge clk);
        psel = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = AW'(addr);
        pwdata = wdata;
        pstrb = strb;
        pprot = prot;
        #1;
        checkOutput("setup_pready", 32'(pready), 32'd0);
        checkOutput("setup_prdata", prdata, 32'd0);
        @(negedge clk);
        penable = 1'b1;
    endtask

    // One complete transfer; leaves PSEL high so the next call is back-to-back.
    task automatic applyStimulus(input bit wr, input int unsigned addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input logic [2:0] prot, output logic [31:0] rd);
        bit err;
        bit known;
        bit done;
        int idx;
        int waits;
        int exp_wait;
        logic [31:0] exp_data;
        err = modelErr(addr, prot);
        idx = int'(addr / 4);
        exp_wait = wr ? WRW : RDW;
        known = 1'b1;
        exp_data = 32'd0;
        if (!wr && !err) begin
            known = model_valid[idx];
            exp_data = model_mem[idx];
        end
        driveSetup(wr, addr, wdata, strb, prot);
        waits = 0;
        done = 1'b0;
        rd = 32'd0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (pready) begin
                done = 1'b1;
                rd = prdata;
            end else begin
                checkOutput("wait_prdata", prdata, 32'd0);
                checkOutput("wait_pslverr", 32'(pslverr), 32'd0);
                waits++;
                @(negedge clk);
            end
        end
        checkOutput("pready_seen", 32'(done), 32'd1);
        if (done) begin
            checkOutput(wr ? "wr_latency" : "rd_latency", 32'(waits), 32'(exp_wait));
            checkOutput("pslverr", 32'(pslverr), 32'(err));
            if (known) checkOutput(wr ? "wr_prdata" : "rd_prdata", prdata, exp_data);
            if (wr && !err) begin
                if (strb == 4'hF) model_valid[idx] = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) model_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
        end
    endtask

    task automatic abortWrite(input int unsigned addr, input logic [31:0] wdata);
        driveSetup(1'b1, addr, wdata, 4'hF, 3'b001);
        #1;
        checkOutput("abort_wait_pready", 32'(pready), 32'd0);
        @(negedge clk);
        psel = 1'b0;
        penable = 1'b0;
        #1;
        checkOutput("abort_pready", 32'(pready), 32'd0);
        checkOutput("abort_pslverr", 32'(pslverr), 32'd0);
        idleCycle();
    endtask

    // Reset either in a wait cycle or in the completing cycle before its edge.
    task automatic resetDuring(input bit wr, input int unsigned addr, input logic [31:0] wdata,
                               input bit at_completion);
        bit seen;
        driveSetup(wr, addr, wdata, 4'hF, 3'b001);
        seen = 1'b0;
        if (at_completion) begin
            for (int c = 0; c < 40 && !seen; c++) begin
                #1;
                if (pready) seen = 1'b1;
                else @(negedge clk);
            end
        end else begin
            #1;
        end
        checkOutput("pre_reset_pready", 32'(pready), 32'(at_completion));
        #1 preset = 1'b1;
        #1;
        checkOutput("reset_mid_pready", 32'(pready), 32'd0);
        checkOutput("reset_mid_pslverr", 32'(pslverr), 32'd0);
        checkOutput("reset_mid_prdata", prdata, 32'd0);
        psel = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        preset = 1'b0;
        idleCycle();
    endtask

    initial begin
        logic [31:0] rd;
        int unsigned addr;
        int sel;
        preset = 1'b1;
        psel = 1'b0;
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = '0;
        pwdata = '0;
        pstrb = '0;
        pprot = '0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_pready", 32'(pready), 32'd0);
        checkOutput("reset_pslverr", 32'(pslverr), 32'd0);
        checkOutput("reset_prdata", prdata, 32'd0);
        @(negedge clk);
        preset = 1'b0;
        idleCycle();

        $display("[TB] first write and read-after-write");
        applyStimulus(1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 3'b001, rd);
        applyStimulus(1'b0, 32'h010, 32'h0, 4'h0, 3'b001, rd);
        checkOutput("first_read", rd, 32'hDEADBEEF);
        idleCycle();

        $display("[TB] byte strobes");
        applyStimulus(1'b1, 32'h010, 32'h11223344, 4'b0101, 3'b001, rd);
        applyStimulus(1'b0, 32'h010, 32'h0, 4'h0, 3'b001, rd);
        checkOutput("strobe_merge", rd, 32'hDE22BE44);
        applyStimulus(1'b1, 32'h010, 32'hFFFFFFFF, 4'h0, 3'b001, rd);
        applyStimulus(1'b0, 32'h010, 32'h0, 4'h0, 3'b001, rd);
        checkOutput("strobe_zero_noop", rd, 32'hDE22BE44);

        $display("[TB] error responses");
        applyStimulus(1'b1, 32'h000, 32'hCAFEF00D, 4'hF, 3'b001, rd);
        applyStimulus(1'b0, 32'h012, 32'h0, 4'h0, 3'b001, rd);
        applyStimulus(1'b1, 32'(DEPTH * 4), 32'h12345678, 4'hF, 3'b001, rd);
        applyStimulus(1'b0, 32'h000, 32'h0, 4'h0, 3'b001, rd);
        checkOutput("oor_no_alias", rd, 32'hCAFEF00D);

        $display("[TB] abort during write wait");
        applyStimulus(1'b1, 32'h020, 32'hA5A5A5A5, 4'hF, 3'b001, rd);
        abortWrite(32'h020, 32'h5A5A5A5A);
        applyStimulus(1'b0, 32'h020, 32'h0, 4'h0, 3'b001, rd);
        checkOutput("abort_old_data", rd, 32'hA5A5A5A5);

        $display("[TB] protection region");
        applyStimulus(1'b1, 32'(600 * 4), 32'hAAAA0000, 4'hF, 3'b001, rd);
        applyStimulus(1'b1, 32'(600 * 4), 32'h0000BBBB, 4'hF, 3'b000, rd);
        applyStimulus(1'b0, 32'(600 * 4), 32'h0, 4'h0, 3'b001, rd);
        applyStimulus(1'b1, 32'(600 * 4), 32'h22222222, 4'hF, 3'b001, rd);
        applyStimulus(1'b0, 32'(600 * 4), 32'h0, 4'h0, 3'b001, rd);
        checkOutput("prot_ok_write", rd, 32'h22222222);

        $display("[TB] reset mid-transfer");
        applyStimulus(1'b1, 32'h030, 32'h13579BDF, 4'hF, 3'b001, rd);
        resetDuring(1'b1, 32'h030, 32'hFFFFFFFF, 1'b1);
        applyStimulus(1'b0, 32'h030, 32'h0, 4'h0, 3'b001, rd);
        checkOutput("reset_keeps_mem", rd, 32'h13579BDF);
        resetDuring(1'b0, 32'h030, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h030, 32'h0, 4'h0, 3'b001, rd);
        checkOutput("reset_read_after", rd, 32'h13579BDF);

        $display("[TB] random traffic");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'((64 + i) * 4), $urandom, 4'hF, 3'b001, rd);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'((600 + i) * 4), $urandom, 4'hF, 3'b001, rd);
        end
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 5) addr = (64 + $urandom_range(0, 7)) * 4;
            else if (sel <= 7) addr = (600 + $urandom_range(0, 3)) * 4;
            else if (sel == 8) addr = (64 + $urandom_range(0, 7)) * 4 + $urandom_range(1, 3);
            else addr = (DEPTH + $urandom_range(0, DEPTH - 1)) * 4;
            applyStimulus(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
                          3'($urandom_range(0, 7)), rd);
            if ($urandom_range(0, 4) == 0) idleCycle();
        end
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
